dbfs_mul_pipe: RTL and testbench



---
 rtl/dbfs_mul_pipe_if.sv | 31 +++
 rtl/dbfs_mul_pipe.sv | 134 +++++++++++++
 tb/tb_dbfs_mul_pipe.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dbfs_mul_pipe_if.sv
// rtl/dbfs_mul_pipe_if.sv - sample/result bus of the dBFS pipelined multiplier
//
// Ports (master = sample producer, slave = multiplier):
//   in_valid  master->slave  din0/din1 carry a sample
//   din0      master->slave  operand 0, DIN0_WIDTH bits
//   din1      master->slave  operand 1, DIN1_WIDTH bits
//   out_valid slave->master  dout/ovf carry a result
//   dout      slave->master  result, DOUT_WIDTH bits
//   ovf       slave->master  result left the dout range, qualified by out_valid
interface dbfs_mul_pipe_if #(
  parameter int DIN0_WIDTH = 6,
  parameter int DIN1_WIDTH = 43,
  parameter int DOUT_WIDTH = 47
);
  logic                  in_valid;
  logic [DIN0_WIDTH-1:0] din0;
  logic [DIN1_WIDTH-1:0] din1;
  logic                  out_valid;
  logic [DOUT_WIDTH-1:0] dout;
  logic                  ovf;

  modport master (
    output in_valid, din0, din1,
    input  out_valid, dout, ovf
  );

  modport slave (
    input  in_valid, din0, din1,
    output out_valid, dout, ovf
  );
endinterface

// File: rtl/dbfs_mul_pipe.sv
// rtl/dbfs_mul_pipe.sv - pipelined multiplier with shift, rounding and saturation
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset, overrides ce
//   ce     clock enable for every register in the block
//   bus    dbfs_mul_pipe_if slave: in_valid/din0/din1 in, out_valid/dout/ovf out
//
// Stage 1 registers the operands, stages 2..NUM_STAGE-1 carry the full
// product, the last stage rounds, shifts and range-checks into dout/ovf.
module dbfs_mul_pipe #(
  parameter int DIN0_WIDTH  = 6,
  parameter int DIN1_WIDTH  = 43,
  parameter int DOUT_WIDTH  = 47,
  parameter int NUM_STAGE   = 3,
  parameter int DIN0_SIGNED = 1,
  parameter int DIN1_SIGNED = 0,
  parameter int SHIFT       = 0,
  parameter int ROUND       = 0,
  parameter int SATURATE    = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce,
  dbfs_mul_pipe_if.slave bus
);
  // One extra bit over the operand widths holds any signed/unsigned product.
  localparam int  P          = DIN0_WIDTH + DIN1_WIDTH + 1;
  localparam int  D          = NUM_STAGE - 2;
  localparam bit  OUT_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);
  localparam bit  RND_EN     = (ROUND != 0) && (SHIFT > 0);
  localparam int  RSH        = (SHIFT > 0) ? SHIFT - 1 : 0;
  // Range compare is done wide enough for both the shifted product and the bounds.
  localparam int  CW         = ((P + 2) > (DOUT_WIDTH + 2)) ? P + 2 : DOUT_WIDTH + 2;
  localparam logic signed [CW-1:0] MAX_V = OUT_SIGNED ?
      (CW'(1) <<< (DOUT_WIDTH - 1)) - CW'(1) : (CW'(1) <<< DOUT_WIDTH) - CW'(1);
  localparam logic signed [CW-1:0] MIN_V = OUT_SIGNED ?
      -(CW'(1) <<< (DOUT_WIDTH - 1)) : CW'(0);

  logic                  s1_valid;
  logic [DIN0_WIDTH-1:0] s1_din0;
  logic [DIN1_WIDTH-1:0] s1_din1;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_din0  <= '0;
      s1_din1  <= '0;
    end else if (ce) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_din0 <= bus.din0;
        s1_din1 <= bus.din1;
      end
    end
  end

  logic signed [P-1:0] op0_ext, op1_ext, prod;

  always_comb begin
    op0_ext = P'(s1_din0);
    op1_ext = P'(s1_din1);
    if (DIN0_SIGNED != 0) op0_ext = P'($signed(s1_din0));
    if (DIN1_SIGNED != 0) op1_ext = P'($signed(s1_din1));
    prod = op0_ext * op1_ext;
  end

  logic signed [P-1:0] fin_prod;
  logic                fin_valid;

  if (D > 0) begin : g_pipe
    logic signed [P-1:0] p_q [D];
    logic                v_q [D];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < D; k++) begin
          p_q[k] <= '0;
          v_q[k] <= 1'b0;
        end
      end else if (ce) begin
        v_q[0] <= s1_valid;
        if (s1_valid) p_q[0] <= prod;
        for (int k = 1; k < D; k++) begin
          v_q[k] <= v_q[k-1];
          if (v_q[k-1]) p_q[k] <= p_q[k-1];
        end
      end
    end

    assign fin_prod  = p_q[D-1];
    assign fin_valid = v_q[D-1];
  end else begin : g_nopipe
    // Two-stage build: the multiply feeds the final stage directly.
    assign fin_prod  = prod;
    assign fin_valid = s1_valid;
  end

  logic signed [P:0]      rounded, shifted;
  logic signed [CW-1:0]   wide;
  logic [DOUT_WIDTH-1:0]  res;
  logic                   res_ovf;

  always_comb begin
    // P+1 bits so the rounding add can never wrap.
    rounded = (P+1)'(fin_prod);
    if (RND_EN) rounded = rounded + ((P+1)'(1) <<< RSH);
    shifted = rounded >>> SHIFT;
    wide    = CW'(shifted);
    res     = wide[DOUT_WIDTH-1:0];
    res_ovf = 1'b0;
    if (wide > MAX_V) begin
      res_ovf = 1'b1;
      if (SATURATE != 0) res = MAX_V[DOUT_WIDTH-1:0];
    end else if (wide < MIN_V) begin
      res_ovf = 1'b1;
      if (SATURATE != 0) res = MIN_V[DOUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.dout      <= '0;
      bus.ovf       <= 1'b0;
    end else if (ce) begin
      bus.out_valid <= fin_valid;
      if (fin_valid) begin
        bus.dout <= res;
        bus.ovf  <= res_ovf;
      end
    end
  end
endmodule

// File: tb/tb_dbfs_mul_pipe.sv
// tb/tb_dbfs_mul_pipe.sv - testbench for dbfs_mul_pipe
module tb_dbfs_mul_pipe;
  localparam int NI = 6;
  localparam int W0 [NI] = '{6, 6, 8, 8, 8, 7};
  localparam int W1 [NI] = '{43, 43, 8, 8, 8, 9};
  localparam int DW [NI] = '{47, 47, 12, 12, 10, 9};
  localparam int NS [NI] = '{3, 3, 3, 3, 2, 5};
  localparam int S0 [NI] = '{1, 1, 1, 1, 0, 0};
  localparam int S1 [NI] = '{0, 0, 1, 1, 1, 0};
  localparam int SH [NI] = '{0, 0, 4, 4, 3, 2};
  localparam int RD [NI] = '{0, 0, 1, 0, 1, 0};
  localparam int SA [NI] = '{1, 0, 1, 1, 1, 0};

  typedef struct {
    int          inst;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] dout;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        iv [NI];
  logic [63:0] ia [NI];
  logic [63:0] ib [NI];
  logic        ov [NI];
  logic        of [NI];
  logic [63:0] od [NI];

  logic        m_ov [NI];
  logic        m_of [NI];
  logic [63:0] m_d  [NI];
  logic [65:0] sbq  [NI][$];
  logic [65:0] mon_e;
  logic [63:0] cap [$];
  bit          started = 1'b0;
  bit          last_ce = 1'b0;
  bit          last_rst = 1'b0;
  bit          cap_en = 1'b0;
  int          n_pass = 0;
  int          n_chk = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dbfs_mul_pipe_if #(.DIN0_WIDTH(W0[g]), .DIN1_WIDTH(W1[g]), .DOUT_WIDTH(DW[g])) bus ();
    dbfs_mul_pipe #(
      .DIN0_WIDTH(W0[g]), .DIN1_WIDTH(W1[g]), .DOUT_WIDTH(DW[g]), .NUM_STAGE(NS[g]),
      .DIN0_SIGNED(S0[g]), .DIN1_SIGNED(S1[g]), .SHIFT(SH[g]), .ROUND(RD[g]),
      .SATURATE(SA[g])
    ) u_dut (
      .clk(clk), .reset(reset), .ce(ce), .bus(bus)
    );
    assign bus.in_valid = iv[g];
    assign bus.din0     = ia[g][W0[g]-1:0];
    assign bus.din1     = ib[g][W1[g]-1:0];
    assign ov[g]        = bus.out_valid;
    assign of[g]        = bus.ovf;
    assign od[g]        = 64'(bus.dout);
  end

  // Reference: exact integer product in 128 bits, then round/shift/clamp.
  function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b, input int i);
    logic signed [127:0] one, av, bv, p, mx, mn;
    logic ovf;
    one = 128'sd1;
    av = '0; av[63:0] = a; av = av & ((one <<< W0[i]) - one);
    bv = '0; bv[63:0] = b; bv = bv & ((one <<< W1[i]) - one);
    if (S0[i] != 0 && a[W0[i]-1]) av = av - (one <<< W0[i]);
    if (S1[i] != 0 && b[W1[i]-1]) bv = bv - (one <<< W1[i]);
    p = av * bv;
    if (RD[i] != 0 && SH[i] > 0) p = p + (one <<< (SH[i] - 1));
    p = p >>> SH[i];
    if (S0[i] != 0 || S1[i] != 0) begin
      mx = (one <<< (DW[i] - 1)) - one;
      mn = -(one <<< (DW[i] - 1));
    end else begin
      mx = (one <<< DW[i]) - one;
      mn = '0;
    end
    ovf = 1'b0;
    if (p > mx) begin
      ovf = 1'b1;
      if (SA[i] != 0) p = mx;
    end else if (p < mn) begin
      ovf = 1'b1;
      if (SA[i] != 0) p = mn;
    end
    p = p & ((one <<< DW[i]) - one);
    return {ovf, p[63:0]};
  endfunction

  task automatic check(input string nm, input logic [65:0] act, input logic [65:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard push: one entry per accepted ce edge, bubbles included.
  always @(posedge clk) begin
    last_ce  = ce;
    last_rst = reset;
    if (reset) begin
      started = 1'b1;
      for (int i = 0; i < NI; i++) sbq[i].delete();
    end else if (ce) begin
      for (int i = 0; i < NI; i++)
        sbq[i].push_back({iv[i], iv[i] ? model(ia[i], ib[i], i) : 65'd0});
    end
  end

  // Scoreboard pop: expected output state advances only on ce edges.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < NI; i++) begin
        if (last_rst) begin
          m_ov[i] = 1'b0;
          m_of[i] = 1'b0;
          m_d[i]  = '0;
        end else if (last_ce) begin
          if (sbq[i].size() >= NS[i]) begin
            mon_e   = sbq[i].pop_front();
            m_ov[i] = mon_e[65];
            if (mon_e[65]) begin
              m_of[i] = mon_e[64];
              m_d[i]  = mon_e[63:0];
            end
          end else begin
            m_ov[i] = 1'b0;
          end
          if (i == 0 && cap_en && ov[0]) cap.push_back(od[0]);
        end
        check($sformatf("sb%0d", i), {ov[i], of[i], od[i]}, {m_ov[i], m_of[i], m_d[i]});
      end
    end
  end

  initial begin
    vec_t vecs [6];
    int   k;
    int   r;
    vecs[0] = '{0, 64'd5,    64'd1000,            64'd5000,                1'b0};
    vecs[1] = '{0, 64'h20,   64'h7FF_FFFF_FFFF,   64'h0000_4000_0000_0000, 1'b1};
    vecs[2] = '{1, 64'h20,   64'h7FF_FFFF_FFFF,   64'd32,                  1'b1};
    vecs[3] = '{2, 64'd3,    64'd5,               64'd1,                   1'b0};
    vecs[4] = '{2, 64'hFD,   64'd5,               64'hFFF,                 1'b0};
    vecs[5] = '{3, 64'd3,    64'd3,               64'd0,                   1'b0};

    reset = 1'b1;
    ce    = 1'b1;
    for (int i = 0; i < NI; i++) begin
      iv[i] = 1'b0;
      ia[i] = '0;
      ib[i] = '0;
    end
    tick();
    tick();
    for (int i = 0; i < NI; i++) check("reset_state", {ov[i], of[i], od[i]}, 66'd0);
    reset = 1'b0;

    for (int t = 0; t < 6; t++) begin
      k = vecs[t].inst;
      iv[k] = 1'b1;
      ia[k] = vecs[t].a;
      ib[k] = vecs[t].b;
      tick();
      iv[k] = 1'b0;
      repeat (NS[k] - 2) tick();
      check("vec_early", ov[k], 0);
      tick();
      check("vec_valid", ov[k], 1);
      check("vec_dout", od[k], vecs[t].dout);
      check("vec_ovf", of[k], vecs[t].ovf);
      tick();
      check("vec_pulse", ov[k], 0);
      check("vec_hold", od[k], vecs[t].dout);
    end

    cap.delete();
    cap_en = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      if (n == 11) begin
        ce = 1'b0;
        iv[0] = 1'b1;
        ia[0] = 64'd3;
        ib[0] = 64'd99;
        repeat (3) begin
          tick();
          check("stall_hold", {ov[0], od[0]}, {1'b1, 64'd56});
        end
        ce = 1'b1;
      end
      iv[0] = 1'b1;
      ia[0] = 64'(n);
      ib[0] = 64'd7;
      tick();
    end
    iv[0] = 1'b0;
    repeat (6) tick();
    cap_en = 1'b0;
    check("stream_cnt", cap.size(), 20);
    for (int n = 0; n < cap.size() && n < 20; n++) check("stream_val", cap[n], 7 * (n + 1));

    for (int n = 1; n <= 3; n++) begin
      iv[5] = 1'b1;
      ia[5] = 64'(n);
      ib[5] = 64'(n + 10);
      tick();
    end
    iv[5] = 1'b1;
    ia[5] = 64'd9;
    ib[5] = 64'd9;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    iv[5] = 1'b0;
    for (int i = 0; i < NI; i++) check("mid_reset", {ov[i], of[i], od[i]}, 66'd0);
    iv[5] = 1'b1;
    ia[5] = 64'd2;
    ib[5] = 64'd3;
    tick();
    iv[5] = 1'b0;
    for (int c = 1; c < NS[5]; c++) begin
      check("post_rst_idle", ov[5], 0);
      tick();
    end
    check("post_rst_valid", ov[5], 1);
    check("post_rst_dout", od[5], 64'd1);

    for (int c = 0; c < 1500; c++) begin
      ce    = ($urandom_range(0, 7) != 0);
      reset = (c == 700);
      for (int i = 0; i < NI; i++) begin
        iv[i] = ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 3);
        ia[i] = (r == 0) ? '1 : (r == 1) ? '0 : {$urandom(), $urandom()};
        r = $urandom_range(0, 3);
        ib[i] = (r == 0) ? '1 : (r == 1) ? '0 : {$urandom(), $urandom()};
      end
      tick();
    end
    reset = 1'b0;
    ce    = 1'b1;
    for (int i = 0; i < NI; i++) iv[i] = 1'b0;
    repeat (8) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
